main_mem_arbiter: RTL
=====================

// Module: main_mem_arbiter
// PURPOSE
//  Shares the single main_memory port between two requesters: port 0 (CPU
//  memory control, fetch/load/store) and port 1 (program loader / debug DMA).
//  Requests are accepted one at a time and sequenced through a fixed-latency
//  read or single-cycle write. Port 0 has fixed priority; a starvation counter
//  guarantees port 1 progress. Sits between main_memory_control / loader and
//  main_memory.
// PARAMETERS
//  ADDR_W        32  address width of requests and memory port
//  DATA_W        32  data width
//  READ_LATENCY  1   cycles from mem_raddr valid to mem_rdata valid (0..7)
//  STARVE_LIMIT  4   consecutive port-0 grants allowed while port 1 waits (>=1)
// PORTS
//  clk       in   1       clock, all state updates on posedge
//  rst       in   1       synchronous reset, active low
//  req0/1    in   1       request; held high until matching gnt pulse
//  we0/1     in   1       1 = write, 0 = read; valid with req
//  addr0/1   in   ADDR_W  word address; valid with req
//  wdata0/1  in   DATA_W  write data; valid with req & we
//  gnt0/1    out  1       one-cycle pulse: request latched, may be dropped/changed
//  done0/1   out  1       one-cycle pulse: transaction complete
//  rdata0/1  out  DATA_W  read data; valid from done pulse until next read done on that port
//  busy      out  1       high in every state except IDLE
//  mem_raddr out  ADDR_W  to main_memory read_address
//  mem_waddr out  ADDR_W  to main_memory write_address
//  mem_wdata out  DATA_W  to main_memory write_data
//  mem_wen   out  1       to main_memory write_enable
//  mem_rdata in   DATA_W  from main_memory read_data
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; gnt*, done*, busy, mem_wen = 0;
//   rdata*, latched addr/wdata/we/owner, mem_* buses, starve_cnt, lat_cnt = 0.
//  mem_wen = (state==ISSUE) & we_q & rst -- no write on a reset cycle.
//  FSM: IDLE -> ISSUE -> [WAIT]* -> DONE -> IDLE.
//   IDLE: if req0|req1, choose winner, latch addr/wdata/we/owner, go ISSUE.
//   ISSUE (1 cycle): gnt[owner]=1; mem_raddr/mem_waddr=addr_q, mem_wdata=wdata_q.
//     write: mem_wen=1, next DONE. read, READ_LATENCY==0: capture mem_rdata,
//     next DONE; else lat_cnt=1, next WAIT.
//   WAIT: hold address; when lat_cnt==READ_LATENCY capture mem_rdata into
//     rdata[owner], next DONE; else lat_cnt++.
//   DONE (1 cycle): done[owner]=1; next IDLE. Requests are not sampled here.
//  Latency, req seen in IDLE at cycle t: gnt at t+1; write done t+2;
//   read done t+2+READ_LATENCY. Max throughput one transaction per 3 (write)
//   or 3+READ_LATENCY (read) cycles.
//  Arbitration (IDLE only): only one req -> it wins. Both -> port 0 wins unless
//   starve_cnt==STARVE_LIMIT, then port 1 wins.
//   starve_cnt: +1 when port 0 wins with req1 high; cleared when port 1 wins
//   or when port 0 wins with req1 low. Saturates at STARVE_LIMIT.
//  Simultaneous req0&req1 from reset: port 0 first.
//  Requests changing outside IDLE are ignored; latched values are used.
//  rdata of the non-owner port is never disturbed. Write does not update rdata.
//  Reset mid-transaction: transaction abandoned, no gnt/done issued afterward,
//   no memory write performed in the reset cycle.
//  Address is not range-checked; wrap/bounds are main_memory's concern.
// TESTING
//  1. Reset: hold rst=0 3 cycles with req0=1 -> all outputs 0, no gnt0; release
//     -> gnt0 on 2nd cycle after release.
//  2. Port-0 write addr=5 data=0xDEADBEEF, then read addr=5 (READ_LATENCY=1)
//     -> mem_wen one cycle, done0 at t+2; read done0 at t+3, rdata0=0xDEADBEEF.
//  3. req0 and req1 held continuously, STARVE_LIMIT=4 -> grant order
//     0,0,0,0,1,0,0,0,0,1; rdata1 unchanged by port-0 reads.
//  4. req1 alone, read addr=0x7FF, READ_LATENCY=0 and 3 -> done1 at t+2 and
//     t+5, rdata1 = memory[0x7FF].
//  5. Port-0 write in flight, rst=0 in ISSUE cycle -> mem_wen=0, memory
//     location unchanged, no done0.
//  6. Requester changes addr/we after gnt while WAIT -> mem_raddr stays at
//     latched value; completed data from original address.

Source files
------------

// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: shares one main_memory port between port 0 (CPU, fixed priority) and port 1 (loader/DMA)
//   clk, rst (sync, active low)
//   req/we/addr/wdata 0/1 in  -> gnt/done/rdata 0/1 out, busy out
//   mem_raddr/mem_waddr/mem_wdata/mem_wen out, mem_rdata in
module main_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [2:0] RLAT = 3'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic we_q, owner, pick1, capture;
  logic [2:0] lat_cnt;
  logic [SW-1:0] starve_cnt;

  // port 1 wins when alone, or when port 0 has used up its consecutive-grant allowance
  assign pick1 = req1 & (~req0 | (starve_cnt == SLIM));
  assign capture = (state == ISSUE & ~we_q & RLAT == 3'd0) | (state == WAIT & lat_cnt == RLAT);

  // strobes are gated by rst so a reset cycle never shows a grant, completion or write
  assign gnt0 = rst & (state == ISSUE) & ~owner;
  assign gnt1 = rst & (state == ISSUE) & owner;
  assign done0 = rst & (state == DONE) & ~owner;
  assign done1 = rst & (state == DONE) & owner;
  assign busy = rst & (state != IDLE);
  assign mem_wen = rst & (state == ISSUE) & we_q;
  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (req0 | req1) ? ISSUE : IDLE;
      ISSUE:   state_n = (we_q | RLAT == 3'd0) ? DONE : WAIT;
      WAIT:    state_n = (lat_cnt == RLAT) ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner      <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (req0 | req1)) begin
        owner      <= pick1;
        addr_q     <= pick1 ? addr1 : addr0;
        wdata_q    <= pick1 ? wdata1 : wdata0;
        we_q       <= pick1 ? we1 : we0;
        starve_cnt <= (pick1 | ~req1) ? '0 : starve_cnt + SW'(starve_cnt != SLIM);
      end
      lat_cnt <= (state == ISSUE) ? 3'd1 : (state == WAIT) ? lat_cnt + 3'd1 : lat_cnt;
      if (capture && owner) rdata1 <= mem_rdata;
      if (capture && !owner) rdata0 <= mem_rdata;
    end
  end
endmodule
